// File: rtl/mcif_rd_req_split_pkg.sv
// mcif_rd_req_split_pkg: shared constants and state type for the per-port read-command splitter.
package mcif_rd_req_split_pkg;
    localparam int AXI_DATA_WIDTH = 256;
    localparam int ATOM_BYTES = AXI_DATA_WIDTH / 8;
    localparam int MAX_BURST = 16;
    localparam int LEN_W = $clog2(MAX_BURST);
    localparam int SIZE_W = 16;
    localparam int PAGE_BYTES = 4096;
    typedef enum logic {IDLE, SPLIT} state_e;
endpackage

// File: rtl/mcif_rd_req_split_if.sv
// mcif_rd_req_split_if: client command and arbiter burst handshakes of one splitter port.
interface mcif_rd_req_split_if;
    import mcif_rd_req_split_pkg::*;
    logic                 cmd_vld;
    logic                 cmd_rdy;
    logic [31:0]          cmd_addr;
    logic [SIZE_W-1:0]    cmd_size;
    logic                 rd_req_vld;
    logic                 rd_req_rdy;
    logic [LEN_W+31:0]    rd_req_pd;
    logic                 busy;
    logic                 cmd_done;
    modport slave (
        input  cmd_vld, cmd_addr, cmd_size, rd_req_rdy,
        output cmd_rdy, rd_req_vld, rd_req_pd, busy, cmd_done
    );
    modport master (
        output cmd_vld, cmd_addr, cmd_size, rd_req_rdy,
        input  cmd_rdy, rd_req_vld, rd_req_pd, busy, cmd_done
    );
endinterface

// File: rtl/mcif_rd_req_split_burst_calc.sv
// mcif_rd_req_split_burst_calc: sizes one burst from the current address and remaining atoms.
module mcif_rd_req_split_burst_calc #(
    parameter int ATOM_BYTES = mcif_rd_req_split_pkg::ATOM_BYTES,
    parameter int MAX_BURST = mcif_rd_req_split_pkg::MAX_BURST,
    parameter int LEN_W = mcif_rd_req_split_pkg::LEN_W,
    parameter int SIZE_W = mcif_rd_req_split_pkg::SIZE_W,
    parameter int PAGE_BYTES = mcif_rd_req_split_pkg::PAGE_BYTES
) (
    input  logic [31:0]       cur_addr_i,
    input  logic [SIZE_W-1:0] rem_m1_i,
    output logic [LEN_W-1:0]  len_m1_o,
    output logic [31:0]       next_addr_o,
    output logic [SIZE_W-1:0] next_rem_o,
    output logic              last_o
);
    localparam int AW = $clog2(ATOM_BYTES);
    localparam int PB = $clog2(PAGE_BYTES);
    localparam int PW = PB - AW;
    logic [SIZE_W:0] rem;
    logic [PW:0]     page_atoms;
    logic [LEN_W:0]  cap;
    logic [LEN_W:0]  n;
    // Address is atom-aligned, so the page remainder is a count of atoms, never zero.
    assign page_atoms = (PW+1)'(PAGE_BYTES / ATOM_BYTES) - {1'b0, cur_addr_i[PB-1:AW]};
    assign rem = {1'b0, rem_m1_i} + (SIZE_W+1)'(1);
    assign cap = (page_atoms < (PW+1)'(MAX_BURST)) ? page_atoms[LEN_W:0] : (LEN_W+1)'(MAX_BURST);
    assign n = (rem < (SIZE_W+1)'(cap)) ? rem[LEN_W:0] : cap;
    assign len_m1_o = LEN_W'(n - (LEN_W+1)'(1));
    assign next_addr_o = cur_addr_i + (32'(n) << AW);
    assign next_rem_o = rem_m1_i - SIZE_W'(n);
    assign last_o = rem == (SIZE_W+1)'(n);
endmodule

// File: rtl/mcif_rd_req_split.sv
// mcif_rd_req_split: splits one client read into page-safe bursts of at most MAX_BURST atoms.
// The output register holds the burst on offer; cur_addr/rem_m1 point at the burst after it.
module mcif_rd_req_split
    import mcif_rd_req_split_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    mcif_rd_req_split_if.slave bus
);
    state_e            state_q, state_d;
    logic [31:0]       cur_addr_q, cur_addr_d;
    logic [SIZE_W-1:0] rem_m1_q, rem_m1_d;
    logic              last_q, last_d;
    logic              vld_q, vld_d;
    logic [LEN_W+31:0] pd_q, pd_d;
    logic [31:0]       calc_addr;
    logic [SIZE_W-1:0] calc_rem;
    logic [LEN_W-1:0]  len_m1;
    logic [31:0]       next_addr;
    logic [SIZE_W-1:0] next_rem;
    logic              last;
    logic              load;

    assign calc_addr = (state_q == IDLE) ? (bus.cmd_addr & ~32'(ATOM_BYTES - 1)) : cur_addr_q;
    assign calc_rem = (state_q == IDLE) ? bus.cmd_size : rem_m1_q;

    mcif_rd_req_split_burst_calc u_calc (
        .cur_addr_i  (calc_addr),
        .rem_m1_i    (calc_rem),
        .len_m1_o    (len_m1),
        .next_addr_o (next_addr),
        .next_rem_o  (next_rem),
        .last_o      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            rem_m1_q   <= '0;
            last_q     <= 1'b0;
            vld_q      <= 1'b0;
            pd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_m1_q   <= rem_m1_d;
            last_q     <= last_d;
            vld_q      <= vld_d;
            pd_q       <= pd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        rem_m1_d     = rem_m1_q;
        last_d       = last_q;
        vld_d        = vld_q;
        pd_d         = pd_q;
        load         = 1'b0;
        bus.cmd_done = 1'b0;
        if (state_q == IDLE) begin
            load    = bus.cmd_vld;
            state_d = bus.cmd_vld ? SPLIT : IDLE;
        end else if (vld_q && bus.rd_req_rdy) begin
            bus.cmd_done = last_q;
            load         = !last_q;
            vld_d        = !last_q;
            state_d      = last_q ? IDLE : SPLIT;
        end
        if (load) begin
            vld_d      = 1'b1;
            pd_d       = {len_m1, calc_addr};
            cur_addr_d = next_addr;
            rem_m1_d   = next_rem;
            last_d     = last;
        end
    end

    assign bus.cmd_rdy    = state_q == IDLE;
    assign bus.busy       = state_q == SPLIT;
    assign bus.rd_req_vld = vld_q;
    assign bus.rd_req_pd  = pd_q;
endmodule

// File: tb/tb_mcif_rd_req_split.sv
// tb_mcif_rd_req_split: directed bench with a burst-list model of the splitter checked every cycle.
module tb_mcif_rd_req_split;
    import mcif_rd_req_split_pkg::*;

    typedef struct {
        logic [LEN_W+31:0] pd;
        bit                last;
    } burst_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cmp = 0;
    int err = 0;
    burst_t q[$];
    logic [LEN_W+31:0] log_q[$];

    mcif_rd_req_split_if bus();

    mcif_rd_req_split dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected burst list straight from the rules: min(remaining, MAX_BURST, atoms left in page).
    task automatic gen(input logic [31:0] addr, input int size);
        logic [31:0] a;
        int rem;
        int page;
        int n;
        burst_t b;
        a = addr & ~32'(ATOM_BYTES - 1);
        rem = size + 1;
        while (rem > 0) begin
            page = (PAGE_BYTES - int'(a % PAGE_BYTES)) / ATOM_BYTES;
            n = rem;
            if (n > MAX_BURST) n = MAX_BURST;
            if (n > page) n = page;
            rem -= n;
            b.pd = {LEN_W'(n - 1), a};
            b.last = (rem == 0);
            q.push_back(b);
            a += 32'(n * ATOM_BYTES);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_vld", bus.rd_req_vld, 0);
            chk("rst_pd", bus.rd_req_pd, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_cmd_rdy", bus.cmd_rdy, 1);
            chk("rst_done", bus.cmd_done, 0);
        end else begin
            chk("vld", bus.rd_req_vld, q.size() != 0);
            chk("busy", bus.busy, q.size() != 0);
            chk("cmd_rdy", bus.cmd_rdy, q.size() == 0);
            if (bus.rd_req_vld && bus.rd_req_rdy) log_q.push_back(bus.rd_req_pd);
            if (q.size() != 0) begin
                chk("pd", bus.rd_req_pd, q[0].pd);
                chk("cmd_done", bus.cmd_done, bus.rd_req_rdy && q[0].last);
                if (bus.rd_req_rdy) void'(q.pop_front());
            end else begin
                chk("done_idle", bus.cmd_done, 0);
                if (bus.cmd_vld) gen(bus.cmd_addr, int'(bus.cmd_size));
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input int size);
        log_q.delete();
        @(posedge clk);
        #1;
        bus.cmd_vld = 1'b1;
        bus.cmd_addr = addr;
        bus.cmd_size = SIZE_W'(size);
        @(posedge clk);
        #1;
        bus.cmd_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("idle_timeout", i < 200, 1);
    endtask

    initial begin
        bus.cmd_vld = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_size = '0;
        bus.rd_req_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(32'h0000_1000, 0);
        wait_idle();
        chk("t1_cnt", log_q.size(), 1);
        chk("t1_b0", log_q[0], {4'd0, 32'h0000_1000});

        issue(32'h0000_0000, 39);
        wait_idle();
        chk("t2_cnt", log_q.size(), 3);
        chk("t2_b0", log_q[0], {4'd15, 32'h0000_0000});
        chk("t2_b1", log_q[1], {4'd15, 32'h0000_0200});
        chk("t2_b2", log_q[2], {4'd7, 32'h0000_0400});

        issue(32'h0000_0FC0, 3);
        wait_idle();
        chk("t3_cnt", log_q.size(), 2);
        chk("t3_b0", log_q[0], {4'd1, 32'h0000_0FC0});
        chk("t3_b1", log_q[1], {4'd1, 32'h0000_1000});

        issue(32'h0000_1005, 0);
        wait_idle();
        chk("t4_cnt", log_q.size(), 1);
        chk("t4_b0", log_q[0], {4'd0, 32'h0000_1000});

        issue(32'h0000_0F00, 20);
        wait_idle();
        chk("t5_cnt", log_q.size(), 2);
        chk("t5_b0", log_q[0], {4'd7, 32'h0000_0F00});
        chk("t5_b1", log_q[1], {4'd12, 32'h0000_1000});

        issue(32'hFFFF_FFE0, 1);
        wait_idle();
        chk("t6_cnt", log_q.size(), 2);
        chk("t6_b0", log_q[0], {4'd0, 32'hFFFF_FFE0});
        chk("t6_b1", log_q[1], {4'd0, 32'h0000_0000});

        // Stall the second burst of a 40-atom read for five cycles.
        issue(32'h0000_0000, 39);
        @(posedge clk);
        #1 bus.rd_req_rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_vld", bus.rd_req_vld, 1);
            chk("stall_pd", bus.rd_req_pd, {4'd15, 32'h0000_0200});
        end
        @(posedge clk);
        #1 bus.rd_req_rdy = 1'b1;
        wait_idle();
        chk("t7_cnt", log_q.size(), 3);
        chk("t7_b1", log_q[1], {4'd15, 32'h0000_0200});
        chk("t7_b2", log_q[2], {4'd7, 32'h0000_0400});

        // Reset right after the first burst is taken; nothing may follow it.
        issue(32'h0000_0000, 39);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t8_cnt", log_q.size(), 1);
        chk("t8_b0", log_q[0], {4'd15, 32'h0000_0000});

        issue(32'h0000_2000, 0);
        wait_idle();
        chk("t9_cnt", log_q.size(), 1);
        chk("t9_b0", log_q[0], {4'd0, 32'h0000_2000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/mcif_rd_req_split.md
Name: mcif_rd_req_split

Overview:
- Per-port read-command splitter, one instance per client port, upstream of the MCIF 4-port read arbiter.
- Accepts one client read of up to 2^SIZE_W atoms and emits a sequence of AXI-legal bursts on rd_req_vld/rdy/pd, in the payload format the arbiter consumes.
- Each burst is at most MAX_BURST atoms and never crosses a 4 KB page.
- Credit accounting stays in the arbiter; this block only shapes commands.

Parameters:
- ATOM_BYTES, 32: bytes per AXI beat (AXI_DATA_WIDTH/8); power of two, 8..128.
- MAX_BURST, 16: maximum atoms per emitted burst; power of two, ≤ 4096/ATOM_BYTES.
- LEN_W, 4: width of the burst length-minus-1 field; equals log2(MAX_BURST).
- SIZE_W, 16: width of the client request size field (atoms minus 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- cmd_vld  in  1  client read command valid
- cmd_rdy  out  1  command accepted when cmd_vld&cmd_rdy
- cmd_addr  in  32  start byte address; low log2(ATOM_BYTES) bits ignored (forced 0)
- cmd_size  in  SIZE_W  total atoms minus 1
- rd_req_vld  out  1  burst valid
- rd_req_rdy  in  1  burst accepted when rd_req_vld&rd_req_rdy
- rd_req_pd  out  LEN_W+32  {len_m1[LEN_W-1:0], addr[31:0]}; len_m1 = beats-1
- busy  out  1  command in progress
- cmd_done  out  1  one-cycle pulse on the cycle the last burst of a command is accepted

Behaviour:
- Reset values: cmd_rdy=1, rd_req_vld=0, rd_req_pd=0, busy=0, cmd_done=0. State = IDLE. Registers cur_addr and rem_m1 cleared.
- FSM states: IDLE and SPLIT.
- IDLE:
  - cmd_rdy=1.
  - On cmd_vld: latch cur_addr = aligned cmd_addr and rem_m1 = cmd_size, move to SPLIT, and load the first burst into the output register.
  - rd_req_vld rises the next cycle, giving 1-cycle latency from acceptance to first burst.
- SPLIT:
  - cmd_rdy=0, busy=1.
  - Burst beat count: n = min(rem_m1+1, MAX_BURST, page_atoms).
  - page_atoms = (4096 - cur_addr[11:0]) / ATOM_BYTES, always ≥ 1.
  - Emitted values: len_m1 = n-1, addr = cur_addr.
- Output register:
  - rd_req_vld/rd_req_pd are registered.
  - While rd_req_vld=1 and rd_req_rdy=0, pd is held stable and vld does not drop.
- On burst acceptance:
  - Update cur_addr += n*ATOM_BYTES (mod 2^32, wraps silently) and rem_m1 -= n.
  - If the remainder is non-zero, the next burst is loaded the same edge, so vld stays 1. Sustained throughput is one burst per cycle.
  - If the accepted burst was the last one: cmd_done=1 for that cycle, vld drops next cycle, state returns to IDLE, cmd_rdy=1 next cycle.
  - Back-to-back commands therefore have a single-cycle bubble.
- Arithmetic widths:
  - rem computed in SIZE_W+1 bits.
  - n computed in log2(MAX_BURST)+1 bits before the -1.
  - No underflow is possible because n ≤ rem_m1+1.
- cmd_size=0 produces exactly one 1-beat burst.
- Reset mid-command: the command in progress is dropped entirely, with no partial bursts after reset. The arbiter does not see a half-transferred pd because vld is forced to 0.
- cmd inputs are ignored outside IDLE; the client must hold them until cmd_rdy.

Decomposition:
- Shared package (vpu_defines): ATOM_BYTES derivation from AXI_DATA_WIDTH, log2MAX_BURST_ATOM_CUBE (=LEN_W), PAGE_BYTES=4096, SIZE_W.
- One natural sub-module, mcif_burst_calc: purely combinational; cur_addr and rem_m1 -> n, len_m1, next_addr, next_rem, last.
- The top level holds the FSM and output register.

Test Plan (ATOM_BYTES=32, MAX_BURST=16, page = 128 atoms):
- addr 0x00001000, size 0, rdy=1 -> one pd {0, 0x00001000} one cycle after acceptance; cmd_done on that beat; cmd_rdy=1 the following cycle.
- addr 0x00000000, size 39 -> three bursts {15,0x000}, {15,0x200}, {7,0x400} on consecutive cycles; cmd_done with the third.
- addr 0x00000FC0, size 3 (page crossing) -> {1,0x00000FC0}, {1,0x00001000}.
- addr 0x00001005, size 0 (unaligned) -> {0,0x00001000}.
- rd_req_rdy low for 5 cycles during the 2nd burst of the size-39 case -> vld=1 and pd={15,0x200} held stable for all 5 cycles; no burst skipped or duplicated.
- rst_n asserted after the first burst of the size-39 case -> vld=0, busy=0, cmd_rdy=1 after release; no further bursts until a new command is issued.
